im2col_ctrl: RTL
================

# im2col_ctrl

Sequencer for the serial-to-parallel data-processing stage of the IMG2COL GEMM path. It walks a K×K convolution window over one input feature map using a configured height, width, padding and stride. Each cycle it issues one tensor read address and one weight read address, plus the `start` and padding-zero qualifiers the S2P buffer consumes. It sits between the tensor/weight SRAMs (1-cycle read latency) and the S2P buffer, and gates each new window on a ready signal from the GEMM array.

## Interface
- `K`, default `` `S2P_SIZE `` (3): kernel edge; one window is K·K elements.
- `DIM_W`, default 8: width of height/width/output-count fields.
- `ADDR_W`, default 16: tensor address width.
- `WADDR_W`, default `$clog2(K*K)`: weight address width.
- `clk`  in  1  clock.
- `rstn`  in  1  asynchronous active-low reset.
- `go`  in  1  start-of-job pulse; sampled only in IDLE.
- `abort`  in  1  synchronous job kill.
- `cfg_h`, `cfg_w`  in  DIM_W  input map height/width; latched at `go`.
- `cfg_pad`  in  2  zero padding P, applied on all sides; latched at `go`.
- `cfg_stride`  in  2  stride S (1..3); latched at `go`.
- `win_ready`  in  1  GEMM can accept the next window.
- `start`  out  1  element valid to S2P buffer.
- `t_padding_zero`  out  1  current tensor element is padding.
- `w_padding_zero`  out  1  always 0 in this revision (reserved).
- `t_addr`  out  ADDR_W  tensor SRAM read address.
- `w_addr`  out  WADDR_W  weight SRAM read address.
- `busy`  out  1  job in progress.
- `done`  out  1  1-cycle pulse after the last window.
- `cfg_err`  out  1  1-cycle pulse when a job is rejected.
- `win_idx`  out  2·DIM_W  index of the current window (oy·OW+ox).

## Operation
- States: IDLE, CHECK, STREAM, WAIT, DONE.
- IDLE → CHECK on `go`. The `cfg_*` fields are latched on that edge.
- CHECK (1 cycle):
  - compute OH = (H+2P−K)/S+1 and OW = (W+2P−K)/S+1 with floor division;
  - if H+2P<K, W+2P<K, or S==0: pulse `cfg_err` and return to IDLE;
  - otherwise clear all counters and go to STREAM.
- STREAM issues one element per cycle with `start`=1. Order: kx innermost, then ky.
  - iy = oy·S+ky−P, ix = ox·S+kx−P, evaluated as signed values of width DIM_W+2.
  - `t_padding_zero` = (iy<0) | (iy≥H) | (ix<0) | (ix≥W).
  - `t_addr` = iy·W+ix when the element is in bounds, else 0.
  - `w_addr` = ky·K+kx.
- On the last element of a window (ky=kx=K−1):
  - if it was the last window (oy=OH−1, ox=OW−1) → DONE;
  - else if `win_ready`=1 in that same cycle → next window's STREAM on the following cycle, with no bubble;
  - else → WAIT.
- WAIT holds `start`=0 and all addresses stable. It moves to STREAM on the cycle after `win_ready`=1.
- Window advance: ox increments first. When ox wraps from OW−1 to 0, oy increments. `win_idx` increments by 1 per window.
- DONE: pulse `done` for 1 cycle, then IDLE.
- `abort`: from any state, go to IDLE on the next edge with `start`=0; no `done`, no `cfg_err`.
  - The S2P element counter is left mid-window, so the system must also reset the S2P stage after an abort.
- `go` is ignored whenever `busy`=1.

## Timing
- Reset values: `start`, `t_padding_zero`, `w_padding_zero`, `busy`, `done`, `cfg_err`, `t_addr`, `w_addr`, `win_idx` are all 0; state is IDLE.
- All outputs are registered.
  - `start`, `t_padding_zero`, `t_addr`, `w_addr` change together and are valid in the same cycle.
  - SRAM data returns one cycle later, aligned with the S2P stage's internally registered `start`/padding qualifiers.
- `go` to first `start`=1 is 2 cycles (CHECK plus state register).
- `busy` rises on the cycle after `go` and falls together with the `done` pulse.
- A window occupies exactly K·K consecutive `start` cycles. The pattern is never split by WAIT or by `win_ready` dropping mid-window.
- With `win_ready` tied high, a job runs for OH·OW·K·K consecutive `start` cycles.
- `done` asserts on the cycle after the final `start` cycle.
- If `abort` and `go` occur in the same cycle in IDLE, `abort` wins.

## Test plan
- H=W=4, P=0, S=1, K=3, `win_ready`=1 → 4 windows, 36 contiguous `start` cycles.
  - Window 0: `t_addr` = 0,1,2,4,5,6,8,9,10; `w_addr` = 0..8.
  - Window 3: `t_addr` starts at 5.
  - `done` asserts 1 cycle after the last `start`.
- H=W=4, P=1, S=1 → 16 windows.
  - Window 0 `t_padding_zero` pattern = 1,1,1,1,0,0,1,0,0.
  - Window 0 in-bounds `t_addr` = 0,1,4,5.
  - Window 15 pad pattern = 0,0,1,0,0,1,1,1,1.
- H=W=5, P=0, S=2 → 4 windows; window 1 first `t_addr` = 2; window 2 first `t_addr` = 10.
- H=W=4, P=0, S=1, with `win_ready` low for 5 cycles after window 0.
  - Expect exactly 5 WAIT cycles with `start`=0 and stable addresses.
  - Window 1 resumes with `t_addr` = 1.
- H=2, W=4, P=0 → `cfg_err` pulses 2 cycles after `go`; `start` never asserts; `busy` returns to 0.
- `abort` on the 4th cycle of window 1 → `start`=0 on the next cycle, IDLE, no `done`. A subsequent `go` runs a full correct job.

Source files
------------

// File: rtl/im2col_ctrl.sv
// im2col_ctrl: walks a KxK convolution window over one input feature map and issues one
// tensor read address and one weight read address per cycle to the S2P buffer.
//
// Ports
//   clk, rstn            clock, asynchronous active-low reset
//   go, abort            job start pulse (IDLE only), synchronous job kill
//   cfg_h, cfg_w         input map height / width, latched at go
//   cfg_pad, cfg_stride  zero padding P and stride S (1..3), latched at go
//   win_ready            GEMM array can accept the next window
//   start                element valid to the S2P buffer
//   t_padding_zero       current tensor element lies in the padding border
//   w_padding_zero       reserved, always 0
//   t_addr, w_addr       tensor / weight SRAM read addresses
//   busy, done, cfg_err  job in progress, end-of-job pulse, rejected-job pulse
//   win_idx              index of the current window (oy*OW+ox)

`ifndef S2P_SIZE
`define S2P_SIZE 3
`endif

module im2col_ctrl #(
   parameter int unsigned K       = `S2P_SIZE,
   parameter int unsigned DIM_W   = 8,
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned WADDR_W = $clog2(K * K)
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 go,
   input  logic                 abort,
   input  logic [DIM_W-1:0]     cfg_h,
   input  logic [DIM_W-1:0]     cfg_w,
   input  logic [1:0]           cfg_pad,
   input  logic [1:0]           cfg_stride,
   input  logic                 win_ready,
   output logic                 start,
   output logic                 t_padding_zero,
   output logic                 w_padding_zero,
   output logic [ADDR_W-1:0]    t_addr,
   output logic [WADDR_W-1:0]   w_addr,
   output logic                 busy,
   output logic                 done,
   output logic                 cfg_err,
   output logic [2*DIM_W-1:0]   win_idx
);

   localparam int unsigned KW = (K > 1) ? $clog2(K) : 1;
   // Signed working width for the input coordinates iy/ix.
   localparam int unsigned IW = DIM_W + 2;
   localparam logic [KW-1:0] KLast = KW'(K - 1);

   typedef enum logic [2:0] {StIdle, StCheck, StStream, StWait, StDone} state_t;

   state_t               state_q, state_d;
   logic [DIM_W-1:0]     h_q, w_q, oh_q, ow_q;
   logic [1:0]           pad_q, stride_q;
   logic [KW-1:0]        kx_q, kx_d, ky_q, ky_d;
   logic [DIM_W-1:0]     ox_q, ox_d, oy_q, oy_d;
   logic [2*DIM_W-1:0]   win_idx_q, win_idx_d;
   logic                 start_q, start_d;
   logic                 pad_zero_q, pad_zero_d;
   logic [ADDR_W-1:0]    t_addr_q, t_addr_d;
   logic [WADDR_W-1:0]   w_addr_q, w_addr_d;
   logic                 busy_q, busy_d, done_q, done_d, cfg_err_q, cfg_err_d;

   logic                 load, adv_win, last_elem, last_win;
   logic [IW-1:0]        h_span, w_span, stride_div, oh_calc, ow_calc;
   logic                 cfg_bad;
   logic [IW-1:0]        iy, ix;
   logic                 pad_calc;

   // Output-map geometry, evaluated from the latched configuration during CHECK.
   always_comb begin
      h_span     = IW'(h_q) + IW'({pad_q, 1'b0});
      w_span     = IW'(w_q) + IW'({pad_q, 1'b0});
      stride_div = (stride_q == 2'd0) ? IW'(1) : IW'(stride_q);
      cfg_bad    = (h_span < IW'(K)) || (w_span < IW'(K)) || (stride_q == 2'd0);
      oh_calc    = (h_span - IW'(K)) / stride_div + IW'(1);
      ow_calc    = (w_span - IW'(K)) / stride_div + IW'(1);
   end

   assign last_elem = (kx_q == KLast) && (ky_q == KLast);
   assign last_win  = (ox_q == ow_q - DIM_W'(1)) && (oy_q == oh_q - DIM_W'(1));

   always_comb begin
      state_d   = state_q;
      kx_d      = kx_q;
      ky_d      = ky_q;
      ox_d      = ox_q;
      oy_d      = oy_q;
      win_idx_d = win_idx_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      cfg_err_d = 1'b0;
      load      = 1'b0;
      adv_win   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (go) begin
               state_d = StCheck;
               busy_d  = 1'b1;
            end
         end
         StCheck: begin
            if (cfg_bad) begin
               state_d   = StIdle;
               cfg_err_d = 1'b1;
               busy_d    = 1'b0;
            end else begin
               state_d   = StStream;
               kx_d      = '0;
               ky_d      = '0;
               ox_d      = '0;
               oy_d      = '0;
               win_idx_d = '0;
               load      = 1'b1;
            end
         end
         StStream: begin
            if (!last_elem) begin
               load = 1'b1;
               if (kx_q == KLast) begin
                  kx_d = '0;
                  ky_d = ky_q + KW'(1);
               end else begin
                  kx_d = kx_q + KW'(1);
               end
            end else if (last_win) begin
               state_d = StDone;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end else if (win_ready) begin
               adv_win = 1'b1;
            end else begin
               state_d = StWait;
            end
         end
         StWait: begin
            if (win_ready) adv_win = 1'b1;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Window advance: ox first, oy on ox wrap; element counters restart.
      if (adv_win) begin
         state_d   = StStream;
         load      = 1'b1;
         kx_d      = '0;
         ky_d      = '0;
         win_idx_d = win_idx_q + (2*DIM_W)'(1);
         if (ox_q == ow_q - DIM_W'(1)) begin
            ox_d = '0;
            oy_d = oy_q + DIM_W'(1);
         end else begin
            ox_d = ox_q + DIM_W'(1);
         end
      end

      // Abort beats everything, including a same-cycle go.
      if (abort) begin
         state_d   = StIdle;
         kx_d      = kx_q;
         ky_d      = ky_q;
         ox_d      = ox_q;
         oy_d      = oy_q;
         win_idx_d = win_idx_q;
         busy_d    = 1'b0;
         done_d    = 1'b0;
         cfg_err_d = 1'b0;
         load      = 1'b0;
      end
   end

   // Element outputs are computed from the next-state counters so that the registered
   // start/padding/address set always describes the same element.
   always_comb begin
      iy = IW'(oy_d) * IW'(stride_q) + IW'(ky_d) - IW'(pad_q);
      ix = IW'(ox_d) * IW'(stride_q) + IW'(kx_d) - IW'(pad_q);
      // A negative coordinate has its MSB set, so it also fails the upper-bound test.
      pad_calc = iy[IW-1] || (iy >= IW'(h_q)) || ix[IW-1] || (ix >= IW'(w_q));

      start_d    = load;
      pad_zero_d = load && pad_calc;
      t_addr_d   = t_addr_q;
      w_addr_d   = w_addr_q;
      if (load) begin
         t_addr_d = pad_calc ? '0 : ADDR_W'(iy) * ADDR_W'(w_q) + ADDR_W'(ix);
         w_addr_d = WADDR_W'(32'(ky_d) * K + 32'(kx_d));
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= StIdle;
         kx_q       <= '0;
         ky_q       <= '0;
         ox_q       <= '0;
         oy_q       <= '0;
         win_idx_q  <= '0;
         start_q    <= 1'b0;
         pad_zero_q <= 1'b0;
         t_addr_q   <= '0;
         w_addr_q   <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         cfg_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         kx_q       <= kx_d;
         ky_q       <= ky_d;
         ox_q       <= ox_d;
         oy_q       <= oy_d;
         win_idx_q  <= win_idx_d;
         start_q    <= start_d;
         pad_zero_q <= pad_zero_d;
         t_addr_q   <= t_addr_d;
         w_addr_q   <= w_addr_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         cfg_err_q  <= cfg_err_d;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         h_q      <= '0;
         w_q      <= '0;
         pad_q    <= '0;
         stride_q <= '0;
         oh_q     <= '0;
         ow_q     <= '0;
      end else begin
         if (state_q == StIdle && go && !abort) begin
            h_q      <= cfg_h;
            w_q      <= cfg_w;
            pad_q    <= cfg_pad;
            stride_q <= cfg_stride;
         end
         if (state_q == StCheck) begin
            oh_q <= DIM_W'(oh_calc);
            ow_q <= DIM_W'(ow_calc);
         end
      end
   end

   assign start          = start_q;
   assign t_padding_zero = pad_zero_q;
   assign w_padding_zero = 1'b0;
   assign t_addr         = t_addr_q;
   assign w_addr         = w_addr_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign cfg_err        = cfg_err_q;
   assign win_idx        = win_idx_q;

endmodule
